// File: rtl/mod6_pkg.sv
// mod6_pkg
// Shared definitions for the tick-driven modulo-6 counter controller:
//   - state_t      : controller FSM state encoding (IDLE / RUN / PAUSE)
//   - SEG_BLANK    : all segments off (active-low display)
//   - SEG_0..SEG_9 : active-low seven-segment patterns, bit 6 = g ... bit 0 = a
//   - digit_to_seg : helper mapping a 4-bit digit to its segment pattern
package mod6_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;

  function automatic logic [6:0] digit_to_seg(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// seg7_decoder
// Purely combinational 4-bit digit to active-low seven-segment decoder.
// Digits 0-9 map to their glyphs; anything else blanks the display.
// Ports:
//   i_digit [3:0] : digit to display
//   o_seg   [6:0] : active-low segments, bit 6 = g ... bit 0 = a
module seg7_decoder
  import mod6_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = digit_to_seg(i_digit);
  end

endmodule

// File: rtl/mod6_counter_ctrl.sv
// mod6_counter_ctrl
// Modulo-MODULUS up/down counter advanced by a one-cycle tick enable, gated by
// a run/pause controller driven from a debounced-elsewhere pushbutton, with a
// registered seven-segment output. Everything runs on i_50MHz; i_tick is only
// an enable.
// Ports:
//   i_50MHz   : system clock
//   i_rst_n   : asynchronous active-low reset
//   i_tick    : one-cycle count enable
//   i_run_btn : asynchronous pushbutton; each press toggles run/pause
//   i_clr     : synchronous clear to IDLE / count 0
//   i_up_down : 1 = count up, 0 = count down (sampled in the tick cycle)
//   o_count   : current count, 0..MODULUS-1
//   o_wrap    : one-cycle pulse following a wrapping tick
//   o_running : high while in RUN
//   o_seg     : active-low segments of o_count, one cycle behind o_count
module mod6_counter_ctrl
  import mod6_pkg::*;
#(
  parameter int MODULUS = 6,
  parameter int WIDTH   = 3
) (
  input  logic             i_50MHz,
  input  logic             i_rst_n,
  input  logic             i_tick,
  input  logic             i_run_btn,
  input  logic             i_clr,
  input  logic             i_up_down,
  output logic [WIDTH-1:0] o_count,
  output logic             o_wrap,
  output logic             o_running,
  output logic [6:0]       o_seg
);

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic             r_running;
  logic [6:0]       r_seg;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_prev;

  logic             w_press;
  logic [3:0]       w_digit;
  logic [6:0]       w_seg;

  // Two-flop synchronizer plus a history flop; a press is the rising edge of
  // the synchronized button, so a held button yields exactly one press.
  always_ff @(posedge i_50MHz or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= i_run_btn;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_press = r_sync2 & ~r_prev;

  // Controller FSM with counter and registered status outputs.
  // Priority: clear, then press, then tick. A tick in the same cycle as a
  // press is still counted when the current state is RUN, because counting
  // looks at the state before the transition.
  always_ff @(posedge i_50MHz or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_wrap    <= 1'b0;
      r_running <= 1'b0;
    end else if (i_clr) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_wrap    <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_wrap <= 1'b0;

      if (r_state == RUN && i_tick) begin
        if (i_up_down) begin
          if (r_count == MAX_CNT) begin
            r_count <= '0;
            r_wrap  <= 1'b1;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end else begin
          if (r_count == '0) begin
            r_count <= MAX_CNT;
            r_wrap  <= 1'b1;
          end else begin
            r_count <= r_count - 1'b1;
          end
        end
      end

      case (r_state)
        IDLE: begin
          r_count <= '0;
          if (w_press) begin
            r_state   <= RUN;
            r_running <= 1'b1;
          end
        end
        RUN: begin
          if (w_press) begin
            r_state   <= PAUSE;
            r_running <= 1'b0;
          end
        end
        PAUSE: begin
          if (w_press) begin
            r_state   <= RUN;
            r_running <= 1'b1;
          end
        end
        default: begin
          // Unreachable encoding: recover to a known-safe state.
          r_state   <= IDLE;
          r_count   <= '0;
          r_running <= 1'b0;
        end
      endcase
    end
  end

  // Widen or narrow the count onto the decoder's 4-bit digit input.
  generate
    if (WIDTH >= 4) begin : g_digit_trunc
      assign w_digit = r_count[3:0];
    end else begin : g_digit_ext
      assign w_digit = {{(4 - WIDTH){1'b0}}, r_count};
    end
  endgenerate

  seg7_decoder u_seg7_decoder (
    .i_digit (w_digit),
    .o_seg   (w_seg)
  );

  // Segments are registered from the registered count, hence one cycle late.
  always_ff @(posedge i_50MHz or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_seg <= SEG_0;
    end else begin
      r_seg <= w_seg;
    end
  end

  assign o_count   = r_count;
  assign o_wrap    = r_wrap;
  assign o_running = r_running;
  assign o_seg     = r_seg;

endmodule

// File: tb/tb_mod6_counter_ctrl.sv
// Scoreboard bench for mod6_counter_ctrl. A reference model advances once per
// rising edge from the driven inputs and queues the expected outputs; a
// monitor on the falling edge pops and compares against the DUT.
module tb_mod6_counter_ctrl;

  localparam int M = 6;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic       btn;
  logic       clr;
  logic       up;
  logic [2:0] o_count;
  logic       o_wrap;
  logic       o_running;
  logic [6:0] o_seg;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_no  = 0;

  typedef struct {
    int         cnt;
    logic       wrap;
    logic       run;
    logic [6:0] seg;
  } exp_t;

  exp_t sb_q[$];

  // Independent glyph table, active-low {g,f,e,d,c,b,a}.
  logic [6:0] seg_tab [10];

  // Model state: mode 0 = idle, 1 = running, 2 = paused.
  int   m_mode;
  int   m_cnt;
  logic m_wrap;
  logic btn_hist [3]; // button as seen at the previous 1, 2 and 3 edges

  mod6_counter_ctrl #(.MODULUS(M), .WIDTH(3)) dut (
    .i_50MHz   (clk),
    .i_rst_n   (rst_n),
    .i_tick    (tick),
    .i_run_btn (btn),
    .i_clr     (clr),
    .i_up_down (up),
    .o_count   (o_count),
    .o_wrap    (o_wrap),
    .o_running (o_running),
    .o_seg     (o_seg)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Reference model.
  initial begin
    exp_t e;
    int   prev_cnt;
    logic press;
    m_mode = 0; m_cnt = 0; m_wrap = 1'b0;
    for (int i = 0; i < 3; i++) btn_hist[i] = 1'b0;
    forever begin
      @(posedge clk);
      prev_cnt = m_cnt;
      if (!rst_n) begin
        m_mode = 0; m_cnt = 0; m_wrap = 1'b0;
        for (int i = 0; i < 3; i++) btn_hist[i] = 1'b0;
        prev_cnt = 0;
      end else begin
        // A press is recognised two edges after the button was first seen high.
        press = btn_hist[1] && !btn_hist[2];
        btn_hist[2] = btn_hist[1];
        btn_hist[1] = btn_hist[0];
        btn_hist[0] = btn;
        m_wrap = 1'b0;
        if (clr) begin
          m_mode = 0; m_cnt = 0;
        end else begin
          if (m_mode == 1 && tick) begin
            if (up) begin
              m_wrap = (m_cnt == M - 1);
              m_cnt  = (m_cnt + 1) % M;
            end else begin
              m_wrap = (m_cnt == 0);
              m_cnt  = (m_cnt + M - 1) % M;
            end
          end
          if (press) m_mode = (m_mode == 1) ? 2 : 1;
        end
      end
      e.cnt  = m_cnt;
      e.wrap = m_wrap;
      e.run  = (m_mode == 1);
      e.seg  = seg_tab[prev_cnt];
      sb_q.push_back(e);
    end
  end

  // Monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc_no++;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_tests++;
        if (int'(o_count) != e.cnt) begin
          n_fail++;
          $display("FAIL cyc%0d count: got %0d want %0d", cyc_no, o_count, e.cnt);
        end
        n_tests++;
        if (o_wrap !== e.wrap) begin
          n_fail++;
          $display("FAIL cyc%0d wrap: got %0b want %0b", cyc_no, o_wrap, e.wrap);
        end
        n_tests++;
        if (o_running !== e.run) begin
          n_fail++;
          $display("FAIL cyc%0d running: got %0b want %0b", cyc_no, o_running, e.run);
        end
        n_tests++;
        if (o_seg !== e.seg) begin
          n_fail++;
          $display("FAIL cyc%0d seg: got %b want %b", cyc_no, o_seg, e.seg);
        end
      end
    end
  end

  // One cycle of stimulus, changed on the falling edge.
  task automatic step(input logic t, input logic b, input logic c);
    tick = t; btn = b; clr = c;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  // Button held for three cycles; the third cycle carries a tick that
  // coincides with the recognised press.
  task automatic press_with_tick();
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic random_phase(input int n);
    for (int i = 0; i < n; i++) begin
      up = 1'($urandom_range(0, 1));
      step(($urandom_range(0, 99) < 45) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 10) ? ~btn : btn,
           ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0);
    end
  endtask

  task automatic check_reset_now(input string tag);
    n_tests++;
    if (o_count !== 3'd0 || o_wrap !== 1'b0 || o_running !== 1'b0 || o_seg !== 7'b1000000) begin
      n_fail++;
      $display("FAIL %s async_reset: got cnt=%0d wrap=%0b run=%0b seg=%b want 0 0 0 1000000",
               tag, o_count, o_wrap, o_running, o_seg);
    end
  endtask

  initial begin
    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
    seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
    seg_tab[9] = 7'b0010000;

    rst_n = 1'b0; tick = 1'b0; btn = 1'b0; clr = 1'b0; up = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle: ticks are ignored.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);

    // Start, then count up through a wrap with mixed gaps and back-to-back ticks.
    step(1'b0, 1'b1, 1'b0); step(1'b0, 1'b1, 1'b0); step(1'b0, 1'b0, 1'b0);
    idle(2);
    up = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b0, 1'b0);
      idle(i % 3);
    end

    // Clear, restart, then count down from 0 twice.
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0); step(1'b0, 1'b1, 1'b0); step(1'b0, 1'b0, 1'b0);
    idle(2);
    up = 1'b0;
    step(1'b1, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b0);
    idle(2);

    // Pause with a coincident tick, ticks while paused, resume with a tick.
    up = 1'b1;
    press_with_tick();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
    press_with_tick();
    step(1'b1, 1'b0, 1'b0);

    // Reach count 4, then clear together with a tick.
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0); step(1'b0, 1'b1, 1'b0); step(1'b0, 1'b0, 1'b0);
    idle(1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    idle(2);

    // Asynchronous reset mid-count, mid-cycle.
    step(1'b0, 1'b1, 1'b0); step(1'b0, 1'b1, 1'b0); step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    #3 rst_n = 1'b0;
    #1 check_reset_now("midcount");
    @(negedge clk);
    idle(2);
    rst_n = 1'b1;
    idle(2);

    // Held button: one transition only. Then a glitch that misses every edge.
    for (int i = 0; i < 100; i++) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    idle(3);
    #2 btn = 1'b1;
    #5 btn = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);

    random_phase(400);

    // Another asynchronous reset after random activity.
    #3 rst_n = 1'b0;
    #1 check_reset_now("random");
    @(negedge clk);
    rst_n = 1'b1;
    random_phase(200);

    btn = 1'b0; tick = 1'b0; clr = 1'b0;
    idle(4);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
